// File: rtl/mem_ctrl_pkg.sv
// Shared configuration for the memory controller: I/O window base,
// RISC-V load/store width encodings and controller state encoding.
package mem_ctrl_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STORE  = 2'd3
  } state_e;

  // Access length in bytes from the size field funct3[1:0].
  function automatic logic [2:0] access_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load result extension: sign- or zero-extends the assembled raw word
// according to the load funct3.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    case (func3_i)
      F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_o = {24'd0, raw_i[7:0]};
      F3_HU:   ext_o = {16'd0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSB
// accesses onto a one-cycle-latency 8-bit RAM port with an I/O window.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_is_write,
  input  logic [2:0]  lsb_func3,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ext_w;
  logic [1:0]  cap_idx;
  logic        is_read;
  logic        io_stall;

  // step k issues byte k; a read captures byte k-1 one step later because
  // the RAM answers a cycle after the address is presented.
  assign cap_idx  = 2'(step_q - 3'd1);
  assign is_read  = (state_q == ST_IFETCH) || (state_q == ST_LOAD);
  assign io_stall = (state_q == ST_STORE) && (addr_q >= IO_BASE) && io_buffer_full;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    func3_d  = func3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    if_done  = 1'b0;
    lsb_done = 1'b0;

    if (!rdy_in) begin
      // While paused, re-present the address whose byte is captured on resume.
      if (is_read && step_q != 3'd0 && step_q <= len_q)
        mem_a = addr_q + 32'(step_q - 3'd1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!flush) begin
            if (lsb_req) begin
              state_d = lsb_is_write ? ST_STORE : ST_LOAD;
              addr_d  = lsb_addr;
              func3_d = lsb_func3;
              len_d   = access_len(lsb_func3[1:0]);
              wdata_d = lsb_wdata;
              step_d  = 3'd0;
              data_d  = 32'd0;
            end else if (if_req) begin
              state_d = ST_IFETCH;
              addr_d  = if_addr;
              func3_d = F3_W;
              len_d   = 3'd4;
              step_d  = 3'd0;
              data_d  = 32'd0;
            end
          end
        end
        ST_IFETCH, ST_LOAD: begin
          if (step_q < len_q)
            mem_a = addr_q + 32'(step_q);
          if (step_q != 3'd0 && step_q <= len_q)
            data_d[{cap_idx, 3'b000} +: 8] = mem_din;
          if (flush) begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
          end else if (step_q == len_q + 3'd1) begin
            if_done  = (state_q == ST_IFETCH);
            lsb_done = (state_q == ST_LOAD);
            state_d  = ST_IDLE;
            step_d   = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        ST_STORE: begin
          if (step_q < len_q) begin
            if (!io_stall) begin
              mem_wr   = 1'b1;
              mem_a    = addr_q + 32'(step_q);
              mem_dout = wdata_q[{step_q[1:0], 3'b000} +: 8];
              step_d   = step_q + 3'd1;
            end
          end else begin
            lsb_done = 1'b1;
            state_d  = ST_IDLE;
            step_d   = 3'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      len_q   <= 3'd0;
      func3_q <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  load_ext u_load_ext (
    .func3_i (func3_q),
    .raw_i   (data_q),
    .ext_o   (ext_w)
  );

  assign if_data   = if_done ? data_q : 32'd0;
  assign lsb_rdata = (lsb_done && state_q == ST_LOAD) ? ext_w : 32'd0;

endmodule
